// File: rtl/elevator_scheduler_pkg.sv
// Shared definitions for the elevator car sequencer.
// Contents: floor count/width constants, FSM state and travel direction enums, and helpers
// that test a call vector for calls above/below a floor and build a one-hot floor mask.
package elevator_scheduler_pkg;

    localparam int N_FLOORS = 4;
    localparam int FLOOR_W  = 2;

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StMoveUp   = 2'd1,
        StMoveDown = 2'd2,
        StDoorOpen = 2'd3
    } state_e;

    typedef enum logic {
        DirUp   = 1'b0,
        DirDown = 1'b1
    } dir_e;

    function automatic logic any_above(input logic [N_FLOORS-1:0] calls,
                                       input logic [FLOOR_W-1:0]  f);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < N_FLOORS; i++) begin
            if (i > int'(f)) hit = hit | calls[i];
        end
        return hit;
    endfunction

    function automatic logic any_below(input logic [N_FLOORS-1:0] calls,
                                       input logic [FLOOR_W-1:0]  f);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < N_FLOORS; i++) begin
            if (i < int'(f)) hit = hit | calls[i];
        end
        return hit;
    endfunction

    function automatic logic [N_FLOORS-1:0] floor_mask(input logic [FLOOR_W-1:0] f);
        logic [N_FLOORS-1:0] one;
        one = {{(N_FLOORS-1){1'b0}}, 1'b1};
        return one << f;
    endfunction

endpackage

// File: rtl/elevator_scheduler_if.sv
// Button/motor/door/display bundle of the elevator sequencer.
// Signals: req (call pulses, one per floor), door_hold (level), floor (car position),
// moving_up / moving_down / door_open (actuator commands), pending (latched calls).
// master: drives buttons, observes car.  slave: the sequencer.
interface elevator_scheduler_if;
    import elevator_scheduler_pkg::*;

    logic [N_FLOORS-1:0] req;
    logic                door_hold;
    logic [FLOOR_W-1:0]  floor;
    logic                moving_up;
    logic                moving_down;
    logic                door_open;
    logic [N_FLOORS-1:0] pending;

    modport master (
        output req, door_hold,
        input  floor, moving_up, moving_down, door_open, pending
    );

    modport slave (
        input  req, door_hold,
        output floor, moving_up, moving_down, door_open, pending
    );

endinterface

// File: rtl/elevator_scheduler_timer.sv
// Up-counter shared between floor-to-floor travel timing and door dwell timing.
// Ports: clk, rst (async, active-low), clear (sync reset to 0, wins over enable),
// enable (count +1), limit (terminal value), done (count equals limit).
module elevator_scheduler_timer #(
    parameter int unsigned TIMER_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               enable,
    input  logic [TIMER_W-1:0] limit,
    output logic               done
);

    logic [TIMER_W-1:0] count_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (enable) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign done = (count_q == limit);

endmodule

// File: rtl/elevator_scheduler.sv
// 4-floor elevator car sequencer with collective (SCAN) direction policy.
// Ports: clk, rst (async, active-low), bus (slave side of elevator_scheduler_if):
// req/door_hold in; floor, moving_up, moving_down, door_open, pending out.
// Holds the FSM, pending-call register, floor register and direction; one shared timer
// measures both travel and door dwell.
module elevator_scheduler
    import elevator_scheduler_pkg::*;
#(
    parameter int unsigned TRAVEL_CYCLES = 8,
    parameter int unsigned DOOR_CYCLES   = 4,
    parameter int unsigned TIMER_W       = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    elevator_scheduler_if.slave  bus
);

    localparam logic [TIMER_W-1:0] TravelLimit = TIMER_W'(TRAVEL_CYCLES - 1);
    localparam logic [TIMER_W-1:0] DoorLimit   = TIMER_W'(DOOR_CYCLES - 1);
    localparam logic [FLOOR_W-1:0] TopFloor    = FLOOR_W'(N_FLOORS - 1);

    state_e              state_q, state_d;
    dir_e                dir_q, dir_d;
    logic [FLOOR_W-1:0]  floor_q, floor_d;
    logic [N_FLOORS-1:0] pending_q, pending_d;

    logic                tmr_clear, tmr_en, tmr_done;
    logic [TIMER_W-1:0]  tmr_limit;

    logic [N_FLOORS-1:0] eff;
    logic                above, below, ahead, behind, beyond;
    logic [FLOOR_W-1:0]  next_floor;

    // Same-cycle calls take part in every decision.
    assign eff   = pending_q | bus.req;
    assign above = any_above(eff, floor_q);
    assign below = any_below(eff, floor_q);
    assign ahead  = (dir_q == DirUp) ? above : below;
    assign behind = (dir_q == DirUp) ? below : above;

    elevator_scheduler_timer #(
        .TIMER_W (TIMER_W)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (tmr_clear),
        .enable (tmr_en),
        .limit  (tmr_limit),
        .done   (tmr_done)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            dir_q     <= DirUp;
            floor_q   <= '0;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            dir_q     <= dir_d;
            floor_q   <= floor_d;
            pending_q <= pending_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        dir_d      = dir_q;
        floor_d    = floor_q;
        pending_d  = eff;
        tmr_clear  = 1'b0;
        tmr_en     = 1'b0;
        tmr_limit  = TravelLimit;
        next_floor = floor_q;
        beyond     = 1'b0;

        unique case (state_q)
            StIdle: begin
                tmr_clear = 1'b1;
                if (eff[floor_q]) begin
                    state_d   = StDoorOpen;
                    pending_d = eff & ~floor_mask(floor_q);
                end else if (above && (dir_q == DirUp || !below)) begin
                    state_d = StMoveUp;
                    dir_d   = DirUp;
                end else if (below) begin
                    state_d = StMoveDown;
                    dir_d   = DirDown;
                end
            end

            StMoveUp, StMoveDown: begin
                if ((state_q == StMoveUp && floor_q == TopFloor) ||
                    (state_q == StMoveDown && floor_q == '0)) begin
                    // Unreachable by construction; refuse to step off the shaft ends.
                    state_d   = StIdle;
                    tmr_clear = 1'b1;
                end else if (tmr_done) begin
                    tmr_clear  = 1'b1;
                    next_floor = (state_q == StMoveUp) ? floor_q + 1'b1 : floor_q - 1'b1;
                    floor_d    = next_floor;
                    beyond     = (state_q == StMoveUp) ? any_above(eff, next_floor)
                                                       : any_below(eff, next_floor);
                    if (eff[next_floor]) begin
                        state_d   = StDoorOpen;
                        pending_d = eff & ~floor_mask(next_floor);
                    end else if (!beyond) begin
                        state_d = StIdle;
                    end
                end else begin
                    tmr_en = 1'b1;
                end
            end

            StDoorOpen: begin
                tmr_limit = DoorLimit;
                // A call for the open floor is absorbed: it only extends the dwell.
                pending_d = pending_q | (bus.req & ~floor_mask(floor_q));
                if (bus.door_hold || bus.req[floor_q]) begin
                    tmr_clear = 1'b1;
                end else if (tmr_done) begin
                    tmr_clear = 1'b1;
                    if (ahead) begin
                        state_d = (dir_q == DirUp) ? StMoveUp : StMoveDown;
                    end else if (behind) begin
                        dir_d   = (dir_q == DirUp) ? DirDown : DirUp;
                        state_d = (dir_q == DirUp) ? StMoveDown : StMoveUp;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    tmr_en = 1'b1;
                end
            end

            default: begin
                state_d   = StIdle;
                tmr_clear = 1'b1;
            end
        endcase
    end

    // Output decode
    always_comb begin
        bus.floor       = floor_q;
        bus.pending     = pending_q;
        bus.moving_up   = (state_q == StMoveUp);
        bus.moving_down = (state_q == StMoveDown);
        bus.door_open   = (state_q == StDoorOpen);
    end

endmodule

// File: tb/tb_elevator_scheduler.sv
// Self-checking bench for elevator_scheduler: a cycle-level behavioural model (countdown
// timers, integer floor/direction) checked against the DUT every falling edge, plus
// directed scenarios with hand-computed literal expectations.
module tb_elevator_scheduler;

    localparam int TRAVEL = 8;
    localparam int DOOR   = 4;

    localparam int M_IDLE = 0;
    localparam int M_UP   = 1;
    localparam int M_DN   = 2;
    localparam int M_DOOR = 3;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;
    bit   cmp_en;

    elevator_scheduler_if bus();

    elevator_scheduler #(
        .TRAVEL_CYCLES (TRAVEL),
        .DOOR_CYCLES   (DOOR),
        .TIMER_W       (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    typedef struct packed {
        int        mode;
        int        flr;
        int        up;    // 1 = heading up
        int        rem;   // cycles left in current move/dwell
        logic [3:0] pend;
    } model_t;

    model_t m;

    function automatic bit calls_past(input logic [3:0] c, input int f, input int go_up);
        bit r;
        r = 0;
        for (int i = 0; i < 4; i++) begin
            if (go_up != 0 && i > f && c[i]) r = 1;
            if (go_up == 0 && i < f && c[i]) r = 1;
        end
        return r;
    endfunction

    function automatic model_t step(input model_t s, input logic [3:0] r, input logic h);
        model_t     n;
        logic [3:0] eff;
        logic [3:0] here;
        int         nf;
        n    = s;
        eff  = s.pend | r;
        here = 4'b0001 << s.flr;
        n.pend = eff;
        if (s.mode == M_IDLE) begin
            if (eff[s.flr]) begin
                n.mode = M_DOOR; n.rem = DOOR; n.pend = eff & ~here;
            end else if (calls_past(eff, s.flr, 1) && (s.up == 1 || !calls_past(eff, s.flr, 0))) begin
                n.mode = M_UP; n.up = 1; n.rem = TRAVEL;
            end else if (calls_past(eff, s.flr, 0)) begin
                n.mode = M_DN; n.up = 0; n.rem = TRAVEL;
            end
        end else if (s.mode == M_UP || s.mode == M_DN) begin
            if (s.rem > 1) begin
                n.rem = s.rem - 1;
            end else begin
                nf    = (s.mode == M_UP) ? s.flr + 1 : s.flr - 1;
                n.flr = nf;
                n.rem = TRAVEL;
                if (eff[nf]) begin
                    n.mode = M_DOOR; n.rem = DOOR; n.pend = eff & ~(4'b0001 << nf);
                end else if (!calls_past(eff, nf, (s.mode == M_UP) ? 1 : 0)) begin
                    n.mode = M_IDLE;
                end
            end
        end else begin
            n.pend = s.pend | (r & ~here);
            if (h || r[s.flr]) begin
                n.rem = DOOR;
            end else if (s.rem > 1) begin
                n.rem = s.rem - 1;
            end else if (calls_past(eff, s.flr, s.up)) begin
                n.mode = (s.up == 1) ? M_UP : M_DN; n.rem = TRAVEL;
            end else if (calls_past(eff, s.flr, 1 - s.up)) begin
                n.up = 1 - s.up;
                n.mode = (n.up == 1) ? M_UP : M_DN; n.rem = TRAVEL;
            end else begin
                n.mode = M_IDLE;
            end
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m <= '{mode: M_IDLE, flr: 0, up: 1, rem: 0, pend: 4'b0000};
        end else begin
            m <= step(m, bus.req, bus.door_hold);
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            vectors = vectors + 1;
            if (int'(bus.floor) != m.flr || bus.moving_up !== (m.mode == M_UP) ||
                bus.moving_down !== (m.mode == M_DN) || bus.door_open !== (m.mode == M_DOOR) ||
                bus.pending !== m.pend) begin
                miscompares = miscompares + 1;
                $display("FAIL model t=%0t: dut floor=%0d up=%b dn=%b door=%b pend=%b; model floor=%0d mode=%0d pend=%b",
                         $time, bus.floor, bus.moving_up, bus.moving_down, bus.door_open,
                         bus.pending, m.flr, m.mode, m.pend);
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string name, input int act, input int exp);
        vectors = vectors + 1;
        if (act != exp) begin
            miscompares = miscompares + 1;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic pulse(input logic [3:0] r);
        bus.req = r;
        cyc();
        bus.req = 4'b0000;
    endtask

    task automatic wait_door(input string name, input int budget);
        bit seen;
        seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            if (bus.door_open) seen = 1;
            else cyc();
        end
        check(name, int'(seen), 1);
    endtask

    task automatic wait_idle(input string name, input int budget);
        bit seen;
        seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            if (!bus.door_open && !bus.moving_up && !bus.moving_down) seen = 1;
            else cyc();
        end
        check(name, int'(seen), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        cmp_en      = 0;
        rst         = 1'b0;
        bus.req       = 4'b0000;
        bus.door_hold = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check("rst_floor", int'(bus.floor), 0);
        check("rst_pending", int'(bus.pending), 0);
        check("rst_outs", int'({bus.moving_up, bus.moving_down, bus.door_open}), 0);
        rst    = 1'b1;
        cmp_en = 1;

        // 1: call to floor 3 from reset
        pulse(4'b1000);
        check("t1_depart_up", int'(bus.moving_up), 1);
        check("t1_depart_floor", int'(bus.floor), 0);
        check("t1_pend3", int'(bus.pending), 8);
        repeat (8) cyc();
        check("t1_floor1", int'(bus.floor), 1);
        repeat (8) cyc();
        check("t1_floor2", int'(bus.floor), 2);
        repeat (8) cyc();
        check("t1_floor3", int'(bus.floor), 3);
        check("t1_door", int'(bus.door_open), 1);
        check("t1_pend_clr", int'(bus.pending), 0);
        repeat (3) cyc();
        check("t1_door_4th", int'(bus.door_open), 1);
        cyc();
        check("t1_idle", int'({bus.moving_up, bus.moving_down, bus.door_open}), 0);

        // 2: intermediate stop at floor 1 on the way 0 -> 3
        pulse(4'b0001);
        check("t2_down", int'(bus.moving_down), 1);
        wait_door("t2_home_door", 40);
        check("t2_home_floor", int'(bus.floor), 0);
        wait_idle("t2_home_idle", 10);
        pulse(4'b1000);
        check("t2_depart", int'(bus.moving_up), 1);
        repeat (2) cyc();
        pulse(4'b0010);
        repeat (5) cyc();
        check("t2_stop1_floor", int'(bus.floor), 1);
        check("t2_stop1_door", int'(bus.door_open), 1);
        check("t2_stop1_pend", int'(bus.pending), 8);
        repeat (3) cyc();
        check("t2_door_4th", int'(bus.door_open), 1);
        cyc();
        check("t2_resume", int'(bus.moving_up), 1);
        repeat (16) cyc();
        check("t2_floor3", int'(bus.floor), 3);
        check("t2_door3", int'(bus.door_open), 1);
        wait_idle("t2_idle", 10);

        // 3: serve 3 first, then reverse down to 0
        pulse(4'b0001);
        wait_door("t3_home_door", 40);
        wait_idle("t3_home_idle", 10);
        pulse(4'b1000);
        pulse(4'b0001);
        repeat (23) cyc();
        check("t3_floor3", int'(bus.floor), 3);
        check("t3_door3", int'(bus.door_open), 1);
        check("t3_pend0", int'(bus.pending), 1);
        repeat (4) cyc();
        check("t3_reverse", int'(bus.moving_down), 1);
        repeat (24) cyc();
        check("t3_floor0", int'(bus.floor), 0);
        check("t3_door0", int'(bus.door_open), 1);
        check("t3_pend_clr", int'(bus.pending), 0);
        wait_idle("t3_idle", 10);

        // 4: door at current floor with door_hold
        pulse(4'b0001);
        check("t4_door", int'(bus.door_open), 1);
        check("t4_nomove", int'({bus.moving_up, bus.moving_down}), 0);
        bus.door_hold = 1'b1;
        repeat (5) cyc();
        bus.door_hold = 1'b0;
        check("t4_held", int'(bus.door_open), 1);
        repeat (3) cyc();
        check("t4_still_open", int'(bus.door_open), 1);
        check("t4_pend", int'(bus.pending), 0);
        cyc();
        check("t4_closed", int'(bus.door_open), 0);

        // 6: call for floor 2 on the arrival edge at floor 2
        pulse(4'b1000);
        repeat (15) cyc();
        check("t6_floor1", int'(bus.floor), 1);
        pulse(4'b0100);
        check("t6_floor2", int'(bus.floor), 2);
        check("t6_door2", int'(bus.door_open), 1);
        check("t6_pend", int'(bus.pending), 8);
        repeat (3) cyc();
        cyc();
        check("t6_continue", int'(bus.moving_up), 1);
        wait_door("t6_door3_wait", 20);
        check("t6_floor3", int'(bus.floor), 3);
        wait_idle("t6_idle", 10);

        // 5: async reset mid-travel
        pulse(4'b0001);
        wait_door("t5_home_door", 40);
        wait_idle("t5_home_idle", 10);
        pulse(4'b1100);
        repeat (11) cyc();
        check("t5_pre_floor", int'(bus.floor), 1);
        check("t5_pre_pend", int'(bus.pending), 12);
        #1 rst = 1'b0;
        #1;
        check("t5_floor", int'(bus.floor), 0);
        check("t5_pend", int'(bus.pending), 0);
        check("t5_outs", int'({bus.moving_up, bus.moving_down, bus.door_open}), 0);
        repeat (2) cyc();
        rst = 1'b1;
        repeat (3) cyc();
        check("t5_after_floor", int'(bus.floor), 0);
        check("t5_after_outs", int'({bus.moving_up, bus.moving_down, bus.door_open}), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
